// File: rtl/oppm_encoder_if.sv
`default_nettype none
// ============================================================================
// Interface : oppm_encoder_if
// Packet handshake and pulse line between a packet source and the OPPM encoder.
// Rev       : 1.0
// ============================================================================
interface oppm_encoder_if #(
   parameter int N_PKT = 8
);
   logic [N_PKT-1:0] data;
   logic             start;
   logic             avail;
   logic             pulse;

   modport master (
      output data,
      output start,
      input  avail,
      input  pulse
   );

   modport slave (
      input  data,
      input  start,
      output avail,
      output pulse
   );
endinterface
`default_nettype wire

// File: rtl/oppm_encoder.sv
`default_nettype none
// ============================================================================
// Module : oppm_encoder
// OPPM transmit encoder: PRE_CT slot-0 sync frames followed by PPM data frames.
// Rev    : 1.0
// ============================================================================
module oppm_encoder #(
   parameter int PULSE_CT = 1,
   parameter int N_MOD    = 2,
   parameter int L        = 4,
   parameter int N_PKT    = 8,
   parameter int PRE_CT   = 3
) (
   input  wire logic     clk,
   input  wire logic     rst,
   oppm_encoder_if.slave bus_io
);
   localparam int SLOT_CT       = 1 << N_MOD;
   localparam int SYM_CYC       = L * SLOT_CT;
   localparam int DATA_PULSE_CT = N_PKT / N_MOD;
   localparam int FRAME_CT      = PRE_CT + DATA_PULSE_CT;
   localparam int CYC_W         = $clog2(SYM_CYC);
   localparam int FRM_W         = $clog2(FRAME_CT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cyc_q,   cyc_d;
   logic [FRM_W-1:0] frm_q,   frm_d;
   logic [N_PKT-1:0] data_q,  data_d;
   logic             avail_q, avail_d;
   logic             pulse_q, pulse_d;

   logic             last_cyc;
   logic             last_frm;
   logic [CYC_W-1:0] tgt_cyc;
   logic [FRM_W-1:0] tgt_frm;
   logic [N_MOD-1:0] tgt_slot;
   logic [CYC_W:0]   tgt_cyc_x;
   logic [CYC_W:0]   slot_lo;
   logic [CYC_W:0]   slot_hi;
   logic             tgt_pulse;

   // Outputs are registered, so everything below is evaluated for the
   // position (frame, cycle) that will be on the wire after the next edge.
   always_comb begin
      last_cyc = (cyc_q == CYC_W'(SYM_CYC - 1));
      last_frm = (frm_q == FRM_W'(FRAME_CT - 1));
      tgt_cyc  = '0;
      tgt_frm  = '0;
      if (state_q != S_IDLE) begin
         tgt_cyc = last_cyc ? '0 : cyc_q + 1'b1;
         tgt_frm = last_cyc ? frm_q + 1'b1 : frm_q;
      end
   end

   always_comb begin
      tgt_slot = '0;
      for (int k = 0; k < DATA_PULSE_CT; k++) begin
         if (tgt_frm == FRM_W'(PRE_CT + k)) begin
            tgt_slot = data_q[N_PKT-1-k*N_MOD -: N_MOD];
         end
      end
   end

   always_comb begin
      tgt_cyc_x = {1'b0, tgt_cyc};
      slot_lo   = (CYC_W+1)'(tgt_slot) * (CYC_W+1)'(L);
      slot_hi   = slot_lo + (CYC_W+1)'(PULSE_CT);
      tgt_pulse = (tgt_cyc_x >= slot_lo) && (tgt_cyc_x < slot_hi);
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      frm_d   = frm_q;
      data_d  = data_q;
      avail_d = avail_q;
      pulse_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            avail_d = 1'b1;
            if (bus_io.start) begin
               data_d  = bus_io.data;
               cyc_d   = '0;
               frm_d   = '0;
               avail_d = 1'b0;
               pulse_d = tgt_pulse;
               state_d = S_PRE;
            end
         end
         S_PRE, S_DATA: begin
            if (last_cyc && last_frm) begin
               cyc_d   = '0;
               frm_d   = '0;
               avail_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cyc_d   = tgt_cyc;
               frm_d   = tgt_frm;
               pulse_d = tgt_pulse;
               state_d = (tgt_frm >= FRM_W'(PRE_CT)) ? S_DATA : S_PRE;
            end
         end
         default: begin
            cyc_d   = '0;
            frm_d   = '0;
            avail_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         frm_q   <= '0;
         data_q  <= '0;
         avail_q <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         frm_q   <= frm_d;
         data_q  <= data_d;
         avail_q <= avail_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus_io.avail = avail_q;
   assign bus_io.pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_oppm_encoder.sv
`default_nettype none
// tb_oppm_encoder: scoreboard and table-driven checks of the OPPM encoder,
// one instance with PULSE_CT=1 and one with PULSE_CT=4.
module tb_oppm_encoder;
   localparam int N_PKT   = 8;
   localparam int N_MOD   = 2;
   localparam int L       = 4;
   localparam int PRE_CT  = 3;
   localparam int SYM_CYC = 16;
   localparam int PKT_CYC = 112;

   typedef logic [PKT_CYC-1:0] wave_t;
   typedef struct {
      logic [7:0] data;
      int         gap;
      int         rise [7];
   } vec_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    n_pass  = 0;
   int    n_total = 0;
   bit    mon_en  = 1'b0;
   wave_t sb_q [$];

   wave_t m_got;
   wave_t m_exp;
   int    m_busy;

   oppm_encoder_if #(.N_PKT(N_PKT)) bus0 ();
   oppm_encoder_if #(.N_PKT(N_PKT)) bus1 ();

   oppm_encoder #(.PULSE_CT(1), .N_MOD(N_MOD), .L(L), .N_PKT(N_PKT), .PRE_CT(PRE_CT)) u_dut0 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus0)
   );

   oppm_encoder #(.PULSE_CT(4), .N_MOD(N_MOD), .L(L), .N_PKT(N_PKT), .PRE_CT(PRE_CT)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus1)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
   endtask

   function automatic wave_t exp_wave(input logic [7:0] d, input int pct);
      wave_t w;
      int f, c, s;
      w = '0;
      for (int t = 0; t < PKT_CYC; t++) begin
         f = t / SYM_CYC;
         c = t % SYM_CYC;
         s = (f < PRE_CT) ? 0 : int'((d >> (N_PKT - N_MOD*(f-PRE_CT+1))) & 8'h3);
         w[t] = (c >= s*L) && (c < s*L + pct);
      end
      return w;
   endfunction

   function automatic wave_t span(input int lo, input int len);
      wave_t w;
      w = '0;
      for (int t = lo; t < lo + len; t++) w[t] = 1'b1;
      return w;
   endfunction

   function automatic int count_falls(input wave_t w);
      int n;
      n = 0;
      for (int t = 0; t < PKT_CYC; t++) begin
         if (w[t]) begin
            if (t == PKT_CYC-1) n++;
            else if (!w[t+1]) n++;
         end
      end
      return n;
   endfunction

   task automatic wait_avail0();
      int n;
      n = 0;
      while (bus0.avail !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("wait_avail", bus0.avail, 1'b1);
   endtask

   task automatic send0(input logic [7:0] d, input int gap, input wave_t req);
      wait_avail0();
      repeat (gap) @(negedge clk);
      bus0.data  = d;
      bus0.start = 1'b1;
      sb_q.push_back(req);
      @(negedge clk);
      bus0.start = 1'b0;
   endtask

   task automatic run1(input logic [7:0] d, input wave_t req, input int falls);
      wave_t got;
      @(negedge clk);
      check("p4_idle", bus1.avail, 1'b1);
      bus1.data  = d;
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      check("p4_accept", bus1.avail, 1'b0);
      got    = '0;
      got[0] = bus1.pulse;
      for (int t = 1; t < PKT_CYC; t++) begin
         @(negedge clk);
         got[t] = bus1.pulse;
      end
      @(negedge clk);
      check("p4_len", bus1.avail, 1'b1);
      check("p4_wave", got, req);
      check("p4_falls", count_falls(got), falls);
   endtask

   // Scoreboard side: every packet seen on bus0 is captured and popped against the queue.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus0.avail === 1'b1) begin
               check("idle_pulse", bus0.pulse, 1'b0);
            end else begin
               m_got    = '0;
               m_got[0] = bus0.pulse;
               m_busy   = 0;
               for (int t = 1; t < PKT_CYC; t++) begin
                  @(negedge clk);
                  m_got[t] = bus0.pulse;
                  if (bus0.avail !== 1'b0) m_busy++;
               end
               @(negedge clk);
               check("pkt_len", bus0.avail, 1'b1);
               check("pkt_end_pulse", bus0.pulse, 1'b0);
               check("pkt_busy_avail", m_busy, 0);
               check("sb_nonempty", sb_q.size() > 0, 1'b1);
               if (sb_q.size() > 0) begin
                  m_exp = sb_q.pop_front();
                  check("pkt_wave", m_got, m_exp);
               end
               check("pkt_falls", count_falls(m_got), PRE_CT + N_PKT/N_MOD);
            end
         end
      end
   end

   initial begin : stim
      vec_t  vecs [5];
      wave_t w;
      int    err;
      int    cnt;
      logic [7:0] d;

      vecs[0].data = 8'hB4; vecs[0].gap = 16; vecs[0].rise = '{0, 16, 32, 56, 76, 84, 96};
      vecs[1].data = 8'h00; vecs[1].gap = 0;  vecs[1].rise = '{0, 16, 32, 48, 64, 80, 96};
      vecs[2].data = 8'hFF; vecs[2].gap = 0;  vecs[2].rise = '{0, 16, 32, 60, 76, 92, 108};
      vecs[3].data = 8'h1B; vecs[3].gap = 3;  vecs[3].rise = '{0, 16, 32, 48, 68, 88, 108};
      vecs[4].data = 8'hE4; vecs[4].gap = 16; vecs[4].rise = '{0, 16, 32, 60, 72, 84, 96};

      bus0.data = '0; bus0.start = 1'b0;
      bus1.data = '0; bus1.start = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_avail", bus0.avail, 1'b1);
      check("rst_pulse", bus0.pulse, 1'b0);
      check("rst_avail_p4", bus1.avail, 1'b1);
      rst = 1'b0;

      // Abort a packet with an asynchronous reset while a preamble pulse is high.
      @(negedge clk);
      bus0.data  = 8'hB4;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      check("accept_avail", bus0.avail, 1'b0);
      check("t0_pulse", bus0.pulse, 1'b1);
      repeat (32) @(negedge clk);
      check("t32_pulse", bus0.pulse, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_avail", bus0.avail, 1'b1);
      check("rst_async_pulse", bus0.pulse, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      err = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus0.pulse !== 1'b0 || bus0.avail !== 1'b1) err++;
      end
      check("post_rst_quiet", err, 0);
      mon_en = 1'b1;

      for (int i = 0; i < 5; i++) begin
         w = '0;
         for (int j = 0; j < 7; j++) w[vecs[i].rise[j]] = 1'b1;
         send0(vecs[i].data, vecs[i].gap, w);
      end

      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom_range(255));
         send0(d, 16 * int'($urandom_range(1)), exp_wave(d, 1));
      end

      // Start pulse while busy must be dropped, not queued.
      send0(8'h5A, 16, exp_wave(8'h5A, 1));
      repeat (20) @(negedge clk);
      bus0.data  = 8'hFF;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      wait_avail0();
      repeat (30) @(negedge clk);

      // start held high: two packets back to back, data changed mid-flight.
      bus0.data  = 8'h1B;
      bus0.start = 1'b1;
      sb_q.push_back(exp_wave(8'h1B, 1));
      sb_q.push_back(exp_wave(8'hE4, 1));
      @(negedge clk);
      check("b2b_t0", bus0.avail, 1'b0);
      cnt = 0;
      while (cnt < 300) begin
         @(negedge clk);
         cnt++;
         if (cnt == 50) bus0.data = 8'hE4;
         if (bus0.avail === 1'b1) break;
      end
      check("b2b_len", cnt, PKT_CYC);
      @(negedge clk);
      check("b2b_gap", bus0.avail, 1'b0);
      bus0.start = 1'b0;
      repeat (40) @(negedge clk);
      bus0.data = 8'h00;
      wait_avail0();

      cnt = 0;
      while (sb_q.size() != 0 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      repeat (2) @(negedge clk);
      check("sb_drain", sb_q.size(), 0);

      run1(8'hFF, span(0,4) | span(16,4) | span(32,4) | span(60,4) | span(76,4) | span(92,4) | span(108,4), 7);
      run1(8'hC3, span(0,4) | span(16,4) | span(32,4) | span(60,8) | span(80,4) | span(108,4), 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
